// File: rtl/audiomini_pkg.sv
// Shared types and constants for the audiomini capture path.
package audiomini_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } capture_state_t;

  localparam logic CH_LEFT    = 1'b0;
  localparam logic CH_RIGHT   = 1'b1;
  localparam int   WRAP_CNT_W = 16;

endpackage

// File: rtl/audiomini_sync_fifo.sv
// Small synchronous FIFO with full/empty flags; the head word is read straight
// from the storage registers, so it is valid as soon as empty is low.
module audiomini_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: the storage is reset too, so the bus shows zeros out of reset
      // rather than unknown data; larger memories would normally be left unreset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/audiomini_capture_writer.sv
// Packs stereo Avalon-ST samples into L/R words and writes them through an
// Avalon-MM master into a circular or one-shot address window.
module audiomini_capture_writer
  import audiomini_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     ast_data,
  input  logic                  ast_channel,
  input  logic                  ast_valid,
  input  logic                  cfg_enable,
  input  logic                  cfg_oneshot,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [ADDR_W-1:0]     cfg_len,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic [2*DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/4-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic                  sts_overflow,
  output logic                  sts_sync_err,
  output logic [WRAP_CNT_W-1:0] sts_wrap_count
);

  capture_state_t      state, state_next;
  logic [ADDR_W-1:0]   wptr, base_q, last_q;
  logic                oneshot_q;
  logic                held_v, pair_v;
  logic [DATA_W-1:0]   held_d;
  logic [2*DATA_W-1:0] pair_d;
  logic                fifo_full, fifo_empty, fifo_clear;
  logic                start, push, accept, at_last, window_end;

  assign start      = (state == IDLE) && cfg_enable;
  assign sts_busy   = (state == RUN) || (state == DRAIN);
  assign avm_write  = sts_busy && !fifo_empty;
  assign accept     = avm_write && !avm_waitrequest;
  assign at_last    = (wptr == last_q);
  assign window_end = accept && at_last && oneshot_q;
  // A pair completed in the last RUN cycle still gets queued while draining.
  assign push       = pair_v && sts_busy;
  // Words queued beyond a finished one-shot window are discarded, never written.
  assign fifo_clear = start || window_end;

  assign avm_address    = wptr;
  assign avm_byteenable = '1;

  audiomini_sync_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (fifo_clear),
    .push    (push),
    .wr_data (pair_d),
    .pop     (accept),
    .rd_data (avm_writedata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // NOTE: the default assignment first makes every path drive state_next,
  // so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_enable) state_next = RUN;
      RUN:     if (window_end) state_next = DONE;
               else if (!cfg_enable) state_next = DRAIN;
      DRAIN:   if (window_end) state_next = DONE;
               else if (fifo_empty && !pair_v) state_next = IDLE;
      DONE:    if (!cfg_enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wptr           <= '0;
      base_q         <= '0;
      last_q         <= '0;
      oneshot_q      <= 1'b0;
      held_v         <= 1'b0;
      held_d         <= '0;
      pair_v         <= 1'b0;
      pair_d         <= '0;
      sts_done       <= 1'b0;
      sts_overflow   <= 1'b0;
      sts_sync_err   <= 1'b0;
      sts_wrap_count <= '0;
    end else begin
      state  <= state_next;
      pair_v <= 1'b0;
      if (start) begin
        base_q         <= cfg_base;
        last_q         <= cfg_base + cfg_len - 1'b1;  // len 0 wraps to the full space
        oneshot_q      <= cfg_oneshot;
        wptr           <= cfg_base;
        held_v         <= 1'b0;
        sts_done       <= 1'b0;
        sts_overflow   <= 1'b0;
        sts_sync_err   <= 1'b0;
        sts_wrap_count <= '0;
      end else begin
        if (state == RUN && ast_valid) begin
          if (ast_channel == CH_LEFT) begin
            if (held_v) sts_sync_err <= 1'b1;
            held_v <= 1'b1;
            held_d <= ast_data;
          end else if (held_v) begin
            pair_v <= 1'b1;
            pair_d <= {ast_data, held_d};
            held_v <= 1'b0;
          end else begin
            sts_sync_err <= 1'b1;
          end
        end
        if (state_next != RUN) held_v <= 1'b0;
        if (push && fifo_full && !accept) sts_overflow <= 1'b1;
        if (accept) begin
          if (!at_last) begin
            wptr <= wptr + 1'b1;
          end else if (oneshot_q) begin
            sts_done <= 1'b1;
          end else begin
            wptr <= base_q;
            if (sts_wrap_count != '1) sts_wrap_count <= sts_wrap_count + 1'b1;
          end
        end
      end
    end
  end

endmodule
